asrv32_uart_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the SoC main memory write port. It receives a framed program image over a UART RX line and assembles little-endian 32-bit words. Each word is written into main memory with a full byte mask, and the ASRV32 core is held in reset until a complete, checksum-valid image is in memory. It shares the memory's data-write interface (address, data, mask, enable) and drives the core's reset.

---
 rtl/asrv32_uart_loader_pkg.sv | 25 ++
 rtl/asrv32_uart_rx.sv | 94 +++++++++
 rtl/asrv32_uart_loader.sv | 163 ++++++++++++++++
 tb/tb_asrv32_uart_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asrv32_uart_loader_pkg.sv
// Shared definitions for the ASRV32 UART boot loader: frame sync byte and
// the state encodings of the loader FSM and the UART receiver.
package asrv32_uart_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StCheck,
    StDone,
    StError
  } loader_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/asrv32_uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchronizer and mid-bit sampling.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_rx           : asynchronous serial line, idle high
//   o_byte_valid   : one-cycle pulse, o_byte holds a received byte
//   o_byte         : last assembled byte (meaningful with o_byte_valid)
//   o_frame_err    : one-cycle pulse when the stop bit samples low
module asrv32_uart_rx
  import asrv32_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e       state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q, frame_err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= RxIdle;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RxIdle: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          // Falling edge only: a line left low after a bad stop bit does not retrigger.
          if (rx_prev_q && !rx_sync_q) state_q <= RxStart;
        end
        RxStart: begin
          if (cnt_q == HalfCnt) begin
            cnt_q   <= '0;
            // Start bit gone high again at mid-bit: treat as a glitch.
            state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == LastCnt) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= RxStop;
            else                   bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == LastCnt) begin
            cnt_q        <= '0;
            state_q      <= RxIdle;
            byte_valid_q <= rx_sync_q;
            frame_err_q  <= !rx_sync_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign o_byte_valid = byte_valid_q;
  assign o_byte       = shift_q;
  assign o_frame_err  = frame_err_q;

endmodule

// File: rtl/asrv32_uart_loader.sv
// Boot loader: receives A5, LEN_LO, LEN_HI, 4*LEN data bytes, CHK over UART,
// writes little-endian words to main memory and releases the core on success.
// Ports:
//   i_clk, i_rst_n        : system clock, asynchronous active-low reset
//   i_uart_rx             : serial input, idle high
//   o_mem_addr/data/wr_*  : main memory write port (single-cycle strobe)
//   o_core_rst_n          : core reset, released only after a valid image
//   o_busy                : load in progress
//   o_error               : sticky error, cleared by a successful load
module asrv32_uart_loader
  import asrv32_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned LOAD_BASE    = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_uart_rx,
  output logic [$clog2(MEMORY_DEPTH)-1:0] o_mem_addr,
  output logic [31:0]                     o_mem_data,
  output logic [3:0]                      o_mem_wr_mask,
  output logic                            o_mem_wr_en,
  output logic                            o_core_rst_n,
  output logic                            o_busy,
  output logic                            o_error
);

  localparam int unsigned AddrW    = $clog2(MEMORY_DEPTH);
  localparam int unsigned IdxW     = $clog2(MEMORY_DEPTH / 4) + 1;
  localparam logic [15:0] MaxWords = 16'(MEMORY_DEPTH / 4 - LOAD_BASE / 4);

  logic       byte_valid, frame_err;
  logic [7:0] rx_byte;

  asrv32_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_uart_rx),
    .o_byte_valid(byte_valid),
    .o_byte      (rx_byte),
    .o_frame_err (frame_err)
  );

  loader_state_e    state_q;
  logic [15:0]      len_q;
  logic [IdxW-1:0]  idx_q;
  logic [1:0]       byte_cnt_q;
  logic [23:0]      word_q;      // first three bytes of the word, newest on top
  logic [7:0]       chk_q;
  logic [AddrW-1:0] mem_addr_q;
  logic [31:0]      mem_data_q;
  logic [3:0]       mem_wr_mask_q;
  logic             mem_wr_en_q, core_rst_n_q, busy_q, error_q;

  logic [15:0] len_full;
  logic [15:0] idx_next;
  assign len_full = {rx_byte, len_q[7:0]};
  assign idx_next = 16'(idx_q) + 16'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      len_q         <= '0;
      idx_q         <= '0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      chk_q         <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_wr_mask_q <= '0;
      mem_wr_en_q   <= 1'b0;
      core_rst_n_q  <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      mem_wr_en_q   <= 1'b0;
      mem_wr_mask_q <= 4'h0;
      if (frame_err && !(state_q inside {StIdle, StDone, StError})) begin
        state_q <= StError;
        busy_q  <= 1'b0;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          StIdle, StError: begin
            if (byte_valid && rx_byte == LOADER_SYNC) begin
              state_q    <= StLenLo;
              chk_q      <= '0;
              idx_q      <= '0;
              byte_cnt_q <= '0;
              busy_q     <= 1'b1;
            end
          end
          StLenLo: begin
            if (byte_valid) begin
              len_q[7:0] <= rx_byte;
              state_q    <= StLenHi;
            end
          end
          StLenHi: begin
            if (byte_valid) begin
              len_q <= len_full;
              if (len_full > MaxWords) begin
                state_q <= StError;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
              end else if (len_full == 16'd0) begin
                state_q <= StCheck;
              end else begin
                state_q <= StData;
              end
            end
          end
          StData: begin
            if (byte_valid) begin
              word_q     <= {rx_byte, word_q[23:8]};
              chk_q      <= chk_q ^ rx_byte;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              if (byte_cnt_q == 2'd3) begin
                // Strobe goes out on the same edge that enters WRITE.
                state_q       <= StWrite;
                mem_wr_en_q   <= 1'b1;
                mem_wr_mask_q <= 4'hF;
                mem_data_q    <= {rx_byte, word_q};
                mem_addr_q    <= AddrW'(LOAD_BASE + (32'(idx_q) << 2));
              end
            end
          end
          StWrite: begin
            idx_q   <= idx_q + 1'b1;
            state_q <= (idx_next == len_q) ? StCheck : StData;
          end
          StCheck: begin
            if (byte_valid) begin
              busy_q <= 1'b0;
              if (rx_byte == chk_q) begin
                state_q      <= StDone;
                core_rst_n_q <= 1'b1;
                error_q      <= 1'b0;
              end else begin
                state_q <= StError;
                error_q <= 1'b1;
              end
            end
          end
          StDone: state_q <= StDone;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign o_mem_addr    = mem_addr_q;
  assign o_mem_data    = mem_data_q;
  assign o_mem_wr_mask = mem_wr_mask_q;
  assign o_mem_wr_en   = mem_wr_en_q;
  assign o_core_rst_n  = core_rst_n_q;
  assign o_busy        = busy_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_asrv32_uart_loader.sv
// Self-checking bench for asrv32_uart_loader: directed frames from the test plan
// plus randomized images, compared against a byte-stream reference model.
module tb_asrv32_uart_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned MD  = 1024;
  localparam int unsigned LB  = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_wr_mask;
  logic        mem_wr_en, core_rst_n, busy, error;

  always #5 clk = ~clk;

  asrv32_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .MEMORY_DEPTH(MD),
    .LOAD_BASE   (LB)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_uart_rx    (rx),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_mem_wr_mask(mem_wr_mask),
    .o_mem_wr_en  (mem_wr_en),
    .o_core_rst_n (core_rst_n),
    .o_busy       (busy),
    .o_error      (error)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [41:0] obs_q[$];
  logic [41:0] exp_q[$];
  int          mask_bad = 0;
  int          strobe_bad = 0;
  bit          wr_prev = 1'b0;

  // Write-port monitor
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      obs_q.push_back({mem_addr, mem_data});
      if (mem_wr_mask !== 4'hF) mask_bad++;
      if (wr_prev) strobe_bad++;
    end else if (mem_wr_mask !== 4'h0) begin
      mask_bad++;
    end
    wr_prev = (mem_wr_en === 1'b1);
  end

  // Reference model: the bytes after a sync are collected in fq, and the
  // frame position alone decides what each byte means.
  bit         m_active, m_done, m_error;
  logic [7:0] fq[$];

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_error = 0;
    fq.delete();
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int n, len;
    logic [7:0] x;
    if (m_done) return;
    if (!m_active) begin
      if (b == 8'hA5) begin m_active = 1; fq.delete(); end
      return;
    end
    fq.push_back(b);
    n = fq.size();
    if (n < 2) return;
    len = int'({fq[1], fq[0]});
    if (n == 2) begin
      if (len > int'(MD / 4 - LB / 4)) begin m_active = 0; m_error = 1; end
    end else if (n <= 2 + 4 * len) begin
      if ((n - 2) % 4 == 0)
        exp_q.push_back({10'(LB + 4 * ((n - 2) / 4 - 1)), fq[n-1], fq[n-2], fq[n-3], fq[n-4]});
    end else begin
      x = 8'h00;
      for (int i = 2; i < n - 1; i++) x ^= fq[i];
      if (b == x) begin m_done = 1; m_error = 0; end
      else m_error = 1;
      m_active = 0;
    end
  endfunction

  function automatic void model_frame_err();
    if (m_active) begin m_active = 0; m_error = 1; end
  endfunction

  function automatic int write_diffs();
    int d, n;
    d = (obs_q.size() != exp_q.size()) ? 1 : 0;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    if (stop_ok) model_byte(b);
    else model_frame_err();
  endtask

  task automatic send_image(input logic [31:0] words[$], input bit bad_chk);
    logic [7:0] chk;
    logic [15:0] len;
    len = 16'(words.size());
    chk = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
    foreach (words[w]) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(words[w][8*k +: 8], 1'b1);
        chk ^= words[w][8*k +: 8];
      end
    end
    send_byte(bad_chk ? (chk ^ 8'h01) : chk, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_q.delete();
    mask_bad = 0;
    strobe_bad = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [41:0] outs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    outs = {mem_wr_en, mem_wr_mask, mem_addr, mem_data, core_rst_n, busy, error};
    tests_run++;
    if (outs !== 42'h0) begin
      tests_failed++;
      $display("FAIL reset_held: outputs=%h expected all zero", outs);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    outs = {mem_wr_en, mem_wr_mask, mem_addr, mem_data, core_rst_n, busy, error};
    tests_run++;
    if (outs !== 42'h0) begin
      tests_failed++;
      $display("FAIL reset_released: outputs=%h expected all zero", outs);
    end
  endtask

  task automatic test_basic();
    logic [31:0] img[$];
    do_reset();
    img = '{32'h0000_0013, 32'h0000_006F};
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
    foreach (img[w]) for (int k = 0; k < 4; k++) send_byte(img[w][8*k +: 8], 1);
    tests_run++;
    if (core_rst_n !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_before_chk: core_rst_n=%b busy=%b expected 0 1", core_rst_n, busy);
    end
    send_byte(8'h7C, 1);
    tests_run++;
    if (obs_q.size() != 2 || obs_q[0] !== {10'h000, 32'h13} || obs_q[1] !== {10'h004, 32'h6F}) begin
      tests_failed++;
      $display("FAIL basic_writes: got %0d writes, first=%h expected 000:00000013, 004:0000006F",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 42'h0);
    end
    tests_run++;
    if ({core_rst_n, busy, error} !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_done: core_rst_n/busy/error=%b expected 100", {core_rst_n, busy, error});
    end
    tests_run++;
    if (mask_bad != 0 || strobe_bad != 0) begin
      tests_failed++;
      $display("FAIL basic_strobe: mask_bad=%0d strobe_bad=%0d expected 0 0", mask_bad, strobe_bad);
    end
    // DONE is terminal: another image must be ignored.
    send_image(img, 1'b1);
    tests_run++;
    if (obs_q.size() != 2 || {core_rst_n, error} !== 2'b10) begin
      tests_failed++;
      $display("FAIL done_terminal: writes=%0d core_rst_n/error=%b expected 2 10",
               obs_q.size(), {core_rst_n, error});
    end
  endtask

  task automatic test_junk_prefix();
    logic [31:0] img[$];
    do_reset();
    img = '{32'h0000_0013, 32'h0000_006F};
    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h5A, 1);
    tests_run++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL junk_ignored: writes=%0d busy=%b expected 0 0", obs_q.size(), busy);
    end
    send_image(img, 1'b0);
    tests_run++;
    if (write_diffs() != 0 || {core_rst_n, busy, error} !== {m_done, m_active, m_error}) begin
      tests_failed++;
      $display("FAIL junk_load: diffs=%0d status=%b expected %b", write_diffs(),
               {core_rst_n, busy, error}, {m_done, m_active, m_error});
    end
  endtask

  task automatic test_bad_chk();
    logic [31:0] img[$];
    do_reset();
    img = '{32'h0000_0013, 32'h0000_006F};
    send_image(img, 1'b1);
    tests_run++;
    if (obs_q.size() != 2 || {core_rst_n, busy, error} !== 3'b001) begin
      tests_failed++;
      $display("FAIL badchk_error: writes=%0d status=%b expected 2 001", obs_q.size(),
               {core_rst_n, busy, error});
    end
    send_image(img, 1'b0);
    tests_run++;
    if (write_diffs() != 0 || {core_rst_n, busy, error} !== 3'b100) begin
      tests_failed++;
      $display("FAIL badchk_reload: diffs=%0d status=%b expected 0 100", write_diffs(),
               {core_rst_n, busy, error});
    end
  endtask

  task automatic test_len_overflow();
    do_reset();
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h01, 1);
    tests_run++;
    if (obs_q.size() != 0 || {core_rst_n, busy, error} !== 3'b001) begin
      tests_failed++;
      $display("FAIL len_overflow: writes=%0d status=%b expected 0 001", obs_q.size(),
               {core_rst_n, busy, error});
    end
  endtask

  task automatic test_frame_err_and_glitch();
    logic [31:0] img[$];
    do_reset();
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
    send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 0);
    tests_run++;
    if (obs_q.size() != 0 || {core_rst_n, busy, error} !== {m_done, m_active, m_error}) begin
      tests_failed++;
      $display("FAIL frame_err: writes=%0d status=%b expected 0 %b", obs_q.size(),
               {core_rst_n, busy, error}, {m_done, m_active, m_error});
    end
    do_reset();
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (60) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0 || {busy, error} !== 2'b00) begin
      tests_failed++;
      $display("FAIL glitch_idle: writes=%0d busy/error=%b expected 0 00", obs_q.size(),
               {busy, error});
    end
    img = '{32'hDEAD_BEEF};
    send_image(img, 1'b0);
    tests_run++;
    if (write_diffs() != 0 || {core_rst_n, busy, error} !== 3'b100) begin
      tests_failed++;
      $display("FAIL glitch_then_load: diffs=%0d status=%b expected 0 100", write_diffs(),
               {core_rst_n, busy, error});
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] img[$];
    do_reset();
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
    send_byte(8'h13, 1); send_byte(8'h00, 1);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_busy: busy=%b expected 1", busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_wr_en, core_rst_n, busy, error} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_async: wr_en/core_rst_n/busy/error=%b expected 0000",
               {mem_wr_en, core_rst_n, busy, error});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_q.delete();
    img = '{32'h0000_0013, 32'h0000_006F};
    send_image(img, 1'b0);
    tests_run++;
    if (write_diffs() != 0 || {core_rst_n, busy, error} !== 3'b100) begin
      tests_failed++;
      $display("FAIL midreset_reload: diffs=%0d status=%b expected 0 100", write_diffs(),
               {core_rst_n, busy, error});
    end
  endtask

  task automatic test_random();
    logic [31:0] img[$];
    logic [7:0]  junk;
    bit          bad;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      img.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h3C;
        send_byte(junk, 1'b1);
      end
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) img.push_back($urandom());
      bad = ($urandom_range(0, 2) == 0);
      send_image(img, bad);
      if (bad) send_image(img, 1'b0);
      tests_run++;
      if (write_diffs() != 0 || {core_rst_n, busy, error} !== {m_done, m_active, m_error}
          || mask_bad != 0 || strobe_bad != 0) begin
        tests_failed++;
        $display("FAIL random_%0d: diffs=%0d status=%b expected %b mask_bad=%0d strobe_bad=%0d",
                 it, write_diffs(), {core_rst_n, busy, error}, {m_done, m_active, m_error},
                 mask_bad, strobe_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_junk_prefix();
    test_bad_chk();
    test_len_overflow();
    test_frame_err_and_glitch();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
